pipe_stage_latch: RTL and testbench
===================================

# pipe_stage_latch

Parametrised, elastic inter-stage pipeline register for the processor datapath, carrying the PC, A, B and IR fields between stages. It adds a valid/ready handshake, flush-to-bubble, and a saturating stall counter on top of the plain latch. It is instantiated between decode and execute, and also at any other stage boundary that needs back-pressure or squash.

## Interface
Parameters:
- DATA_W, 32: width of each of the pc, a, b and ir fields.
- NOP_IR, 0: IR value presented for a bubble.
- CNT_W, 16: stall counter width.

Ports:
- clock  in  1: single clock; all state updates on its rising edge.
- reset  in  1: synchronous, active-high.
- flush  in  1: squash all held contents this cycle.
- in_valid  in  1: upstream offers a bundle.
- in_ready  out  1: block accepts a bundle this cycle.
- in_pc, in_a, in_b, in_ir  in  DATA_W each: incoming bundle.
- out_valid  out  1: output bundle is valid.
- out_ready  in  1: downstream consumes this cycle.
- out_pc, out_a, out_b, out_ir  out  DATA_W each: registered bundle.
- stall_cnt  out  CNT_W: cycles spent stalled with a valid bundle.

## Operation
- Input transfer: in_valid && in_ready at a rising edge.
- Output transfer: out_valid && out_ready at a rising edge.
- Main register M holds one bundle plus a valid bit.
- Bubble contents: pc = a = b = 0, ir = NOP_IR, valid = 0.
- Priority, highest first: reset, flush, then normal handshake.
- Reset: M becomes a bubble, the skid buffer (if present) is emptied, stall_cnt = 0.
- Flush:
  - M becomes a bubble and the skid buffer is emptied.
  - Any input presented in the same cycle is dropped, even if in_ready is high.
  - stall_cnt is unchanged.
- Normal operation without skid:
  - in_ready = !out_valid || out_ready (combinational).
  - On an input transfer, M loads the input bundle and valid = 1.
  - On an output transfer with no input transfer, M loads a bubble.
  - Otherwise M holds.
- stall_cnt: increments each cycle that out_valid && !out_ready && !flush && !reset; saturates at 2^CNT_W−1 and never wraps.
- When out_valid = 0, the out fields are always bubble values, so downstream logic that is not handshake-aware sees a NOP.

## Timing
- Latency: 1 cycle from input transfer to out_valid/out fields.
- Throughput: 1 bundle per cycle while out_ready is held high.
- Reset values: out_valid = 0, out_pc = out_a = out_b = 0, out_ir = NOP_IR, stall_cnt = 0.
- in_ready reset value: 1.
- Simultaneous input and output transfer: M takes the new bundle and there is no bubble cycle.
- Bundle order is strictly preserved; no bundle is duplicated or lost except through flush.
- Reset or flush asserted mid-stall discards the held bundle immediately; out_valid = 0 in the next cycle.

## Configuration
- PIPE_SKID_EN defined:
  - A second one-entry skid register S is added, for a total capacity of 2 bundles.
  - in_ready is a pure register output: in_ready = !S.valid, with no combinational path from out_ready.
  - An input arriving while M is valid and out_ready = 0 goes to S.
  - On an output transfer with S valid, M loads S and S empties in the same edge; an input transfer in that same cycle loads S.
  - in_ready falls in the cycle after S fills, and rises in the cycle after S drains.
- PIPE_SKID_EN undefined:
  - No S register; the combinational in_ready rule applies.
  - Capacity is 1 bundle.

## Test plan
- Reset mid-stream: drive reset for 1 cycle with M valid → next cycle out_valid = 0, out_ir = NOP_IR, out_pc = 0, stall_cnt = 0, in_ready = 1.
- Streaming: in_valid = 1 and out_ready = 1 with pc = 0, 4, 8, … for 8 cycles → out_pc follows one cycle later, one per cycle, in order, with no bubbles.
- Stall:
  - Load pc = 0x10, then drop out_ready for 5 cycles → out_pc holds 0x10 and stall_cnt = 5.
  - Without skid: in_ready = 0 throughout.
  - With PIPE_SKID_EN: exactly one more bundle (pc = 0x14) is accepted, then in_ready = 0; after out_ready returns, 0x10 then 0x14 emerge on consecutive cycles.
- Flush with simultaneous input: flush = 1, in_valid = 1, pc = 0x20 while M holds 0x1C → next cycle out_valid = 0, out_ir = NOP_IR; 0x1C and 0x20 never appear at the output.
- Counter saturation: with CNT_W = 4, stall for 20 cycles → stall_cnt = 15 and it stays at 15.
- Drain to bubble: single bundle with out_ready = 1 and no further input → the cycle after consumption shows out_valid = 0, out_pc = 0, out_ir = NOP_IR.

Source files
------------

// File: rtl/pipe_stage_latch.sv
// Elastic inter-stage pipeline register carrying PC/A/B/IR with valid/ready, flush-to-bubble
// and a saturating stall counter. Define PIPE_SKID_EN to add a one-entry skid register S.
module pipe_stage_latch #(
    parameter int                 DATA_W = 32,
    parameter logic [DATA_W-1:0]  NOP_IR = '0,
    parameter int                 CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [DATA_W-1:0] in_ir,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [DATA_W-1:0] out_ir,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] ir;
    } bundle_t;

    localparam bundle_t BUBBLE = '{pc: '0, a: '0, b: '0, ir: NOP_IR};

    bundle_t in_bundle;
    bundle_t m_q, m_d;
    logic    m_valid, m_valid_d;
    logic    in_xfer, out_xfer;

    assign in_bundle = '{pc: in_pc, a: in_a, b: in_b, ir: in_ir};
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = m_valid && out_ready;

`ifdef PIPE_SKID_EN
    bundle_t s_q, s_d;
    logic    s_valid, s_valid_d;

    // in_ready comes straight from a flop, so out_ready never reaches upstream combinationally
    assign in_ready = !s_valid;

    always_comb begin
        m_d       = m_q;
        m_valid_d = m_valid;
        s_d       = s_q;
        s_valid_d = s_valid;
        if (flush) begin
            m_d       = BUBBLE;
            m_valid_d = 1'b0;
            s_d       = BUBBLE;
            s_valid_d = 1'b0;
        end else if (out_xfer) begin
            if (s_valid) begin
                m_d       = s_q;
                m_valid_d = 1'b1;
                s_d       = in_xfer ? in_bundle : BUBBLE;
                s_valid_d = in_xfer;
            end else if (in_xfer) begin
                m_d       = in_bundle;
                m_valid_d = 1'b1;
            end else begin
                m_d       = BUBBLE;
                m_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            // S is only ever occupied while M is occupied, which keeps bundle order intact
            if (m_valid) begin
                s_d       = in_bundle;
                s_valid_d = 1'b1;
            end else begin
                m_d       = in_bundle;
                m_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s_q     <= BUBBLE;
            s_valid <= 1'b0;
        end else begin
            s_q     <= s_d;
            s_valid <= s_valid_d;
        end
    end
`else
    assign in_ready = !m_valid || out_ready;

    always_comb begin
        m_d       = m_q;
        m_valid_d = m_valid;
        if (flush) begin
            m_d       = BUBBLE;
            m_valid_d = 1'b0;
        end else if (in_xfer) begin
            m_d       = in_bundle;
            m_valid_d = 1'b1;
        end else if (out_xfer) begin
            m_d       = BUBBLE;
            m_valid_d = 1'b0;
        end
    end
`endif

    // M always holds bubble fields while invalid, so the outputs need no masking
    always_ff @(posedge clock) begin
        if (reset) begin
            m_q     <= BUBBLE;
            m_valid <= 1'b0;
        end else begin
            m_q     <= m_d;
            m_valid <= m_valid_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (m_valid && !out_ready && !flush && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign out_valid = m_valid;
    assign out_pc    = m_q.pc;
    assign out_a     = m_q.a;
    assign out_b     = m_q.b;
    assign out_ir    = m_q.ir;

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Directed, table-driven bench for pipe_stage_latch; expectations follow PIPE_SKID_EN when defined.
module tb_pipe_stage_latch;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] A_KEY  = 32'hA5A5_0000;
    localparam logic [31:0] B_OFS  = 32'h0000_0100;
    localparam logic [31:0] IR_OFS = 32'h0000_1000;
`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [31:0] in_pc, in_a, in_b, in_ir;
    logic [31:0] out_pc, out_a, out_b, out_ir;
    logic [3:0]  stall_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst, fl, iv, ordy;
        logic [31:0] pc;
        logic        chk_rdy, exp_rdy, exp_v;
        logic [31:0] exp_pc;
        logic [3:0]  exp_cnt;
    } vec_t;

    vec_t vecs[$];

    pipe_stage_latch #(.DATA_W(32), .NOP_IR(NOP), .CNT_W(4)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_a(in_a), .in_b(in_b), .in_ir(in_ir),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_a(out_a), .out_b(out_b), .out_ir(out_ir),
        .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(input logic rst, fl, iv, ordy, input logic [31:0] pc,
                                input logic chk_rdy, exp_rdy, exp_v,
                                input logic [31:0] exp_pc, input int exp_cnt);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.ordy = ordy; v.pc = pc;
        v.chk_rdy = chk_rdy; v.exp_rdy = exp_rdy; v.exp_v = exp_v;
        v.exp_pc = exp_pc; v.exp_cnt = 4'(exp_cnt);
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, check in_ready before the edge and registered state after it
    task automatic apply_stimulus(input vec_t v, input string tag);
        logic [31:0] e_a, e_b, e_ir;
        @(negedge clock);
        reset     = v.rst;
        flush     = v.fl;
        in_valid  = v.iv;
        out_ready = v.ordy;
        in_pc     = v.pc;
        in_a      = v.pc ^ A_KEY;
        in_b      = v.pc + B_OFS;
        in_ir     = v.pc + IR_OFS;
        #1;
        if (v.chk_rdy) check_output({tag, ".in_ready"}, {31'b0, in_ready}, {31'b0, v.exp_rdy});
        @(posedge clock);
        #1;
        e_a  = v.exp_v ? (v.exp_pc ^ A_KEY)  : 32'h0;
        e_b  = v.exp_v ? (v.exp_pc + B_OFS)  : 32'h0;
        e_ir = v.exp_v ? (v.exp_pc + IR_OFS) : NOP;
        check_output({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, v.exp_v});
        check_output({tag, ".out_pc"}, out_pc, v.exp_v ? v.exp_pc : 32'h0);
        check_output({tag, ".out_a"}, out_a, e_a);
        check_output({tag, ".out_b"}, out_b, e_b);
        check_output({tag, ".out_ir"}, out_ir, e_ir);
        check_output({tag, ".stall_cnt"}, {28'b0, stall_cnt}, {28'b0, v.exp_cnt});
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_a = '0; in_b = '0; in_ir = '0;

        apply_stimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "reset0");

        // Streaming, drain, flush with input, reset mid-stream
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 0, 1, 1, 32'(4 * i), 1, 1, 1, 32'(4 * i), 0));
        vecs.push_back(mk(0, 0, 0, 1, 0,     1, 1, 0, 0,     0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h1C, 1, 1, 1, 32'h1C, 0));
        vecs.push_back(mk(0, 1, 1, 1, 32'h20, 1, 1, 0, 0,     0));
        vecs.push_back(mk(0, 0, 0, 1, 0,     1, 1, 0, 0,     0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h30, 1, 1, 1, 32'h30, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,     0, 0, 1, 32'h30, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0,     0, 0, 0, 0,     0));
        vecs.push_back(mk(0, 0, 0, 0, 0,     1, 1, 0, 0,     0));
        foreach (vecs[i]) apply_stimulus(vecs[i], $sformatf("vec%0d", i));

        // Stall for 5 cycles with 0x14 waiting upstream
        apply_stimulus(mk(0, 0, 1, 0, 32'h10, 1, 1, 1, 32'h10, 0), "stall_load");
        for (int k = 1; k <= 5; k++)
            apply_stimulus(mk(0, 0, 1, 0, 32'h14, 1, SKID && (k == 1), 1, 32'h10, k),
                           $sformatf("stall%0d", k));
        apply_stimulus(mk(0, 0, 1, 1, 32'h14, 1, !SKID, 1, 32'h14, 5), "stall_release");
        apply_stimulus(mk(0, 0, 0, 1, 0,     1, 1, 0, 0,     5), "stall_drain");

        // Flush while stalled; any skid contents must vanish too
        apply_stimulus(mk(0, 0, 1, 0, 32'h50, 1, 1, 1, 32'h50, 5), "fl_load");
        apply_stimulus(mk(0, 0, 1, 0, 32'h54, 1, SKID, 1, 32'h50, 6), "fl_stall");
        apply_stimulus(mk(0, 1, 1, 0, 32'h58, 1, 0, 0, 0, 6), "fl_flush");
        apply_stimulus(mk(0, 0, 0, 1, 0,     1, 1, 0, 0, 6), "fl_after");

        // Counter saturation at 15
        apply_stimulus(mk(1, 0, 0, 0, 0,     0, 0, 0, 0,     0), "sat_reset");
        apply_stimulus(mk(0, 0, 1, 0, 32'h60, 1, 1, 1, 32'h60, 0), "sat_load");
        for (int k = 1; k <= 20; k++)
            apply_stimulus(mk(0, 0, 0, 0, 0, 1, SKID, 1, 32'h60, (k > 15) ? 15 : k),
                           $sformatf("sat%0d", k));
        apply_stimulus(mk(0, 0, 0, 1, 0, 1, 1, 0, 0, 15), "sat_release");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
